tmr_vote_mon: RTL and testbench

Registered, parametrised triple-modular-redundancy voter with per-replica error monitoring. It takes three replicas of a WIDTH-bit word and drives a registered bitwise 2-of-3 majority. It also tracks which replica disagrees with the majority, counts disagreements, and declares a replica faulty after a run of consecutive mismatches. It sits at the output of any triplicated register bank or FSM in the DMB control FPGA, and its status feeds the VME status registers.

---
 rtl/dmb_tmr_pkg.sv | 15 +
 rtl/tmr_replica_mon.sv | 75 +++++++
 rtl/tmr_vote_mon.sv | 78 +++++++
 tb/tb_tmr_vote_mon.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/dmb_tmr_pkg.sv
// Shared types and defaults for the TMR voter and its per-replica monitors.
package dmb_tmr_pkg;

    typedef enum logic [1:0] {
        OK      = 2'b00,
        SUSPECT = 2'b01,
        FAULTY  = 2'b10
    } mon_state_t;

    localparam int CNT_W_DEF     = 8;
    localparam int FAULT_RUN_DEF = 4;
    // FAULT_RUN is limited to 255, so an 8-bit run counter always suffices.
    localparam int RUN_W         = 8;

endpackage

// File: rtl/tmr_replica_mon.sv
// Per-replica health monitor: saturating mismatch counter plus OK/SUSPECT/FAULTY
// tracker that declares a replica faulty after FAULT_RUN consecutive mismatches.
module tmr_replica_mon
    import dmb_tmr_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FAULT_RUN = FAULT_RUN_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             CLR_ERR,
    input  logic             mis,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault
);

    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(FAULT_RUN);

    mon_state_t       state_p1, state_d;
    logic [RUN_W-1:0] run_p1, run_d;
    logic [CNT_W-1:0] err_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

    always_comb begin
        state_d = state_p1;
        run_d   = run_p1;
        case (state_p1)
            OK: begin
                if (mis) begin
                    run_d   = RUN_W'(1);
                    state_d = (FAULT_RUN == 1) ? FAULTY : SUSPECT;
                end
            end
            SUSPECT: begin
                if (mis) begin
                    run_d = run_p1 + 1'b1;
                    if (run_p1 + 1'b1 == RUN_LIM)
                        state_d = FAULTY;
                end else begin
                    run_d   = '0;
                    state_d = OK;
                end
            end
            FAULTY: begin
                state_d = FAULTY;
            end
            default: begin
                state_d = OK;
                run_d   = '0;
            end
        endcase
    end

    // ---- stage 1: monitor state, run length and error count ----
    always_ff @(posedge CLK) begin
        if (RST || CLR_ERR) begin
            state_p1 <= OK;
            run_p1   <= '0;
            err_p1   <= '0;
        end else if (CE) begin
            state_p1 <= state_d;
            run_p1   <= run_d;
            if (mis)
                err_p1 <= sat_inc(err_p1);
        end
    end

    assign err_cnt = err_p1;
    assign fault   = (state_p1 == FAULTY);

endmodule

// File: rtl/tmr_vote_mon.sv
// Registered bitwise 2-of-3 voter with per-replica mismatch flags, a sticky
// multi-replica flag and three replica health monitors.
module tmr_vote_mon
    import dmb_tmr_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FAULT_RUN = FAULT_RUN_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] V,
    output logic [2:0]       MIS,
    output logic             MULTI,
    output logic [CNT_W-1:0] ERR_A,
    output logic [CNT_W-1:0] ERR_B,
    output logic [CNT_W-1:0] ERR_C,
    output logic [2:0]       FAULT
);

    logic [WIDTH-1:0] maj_p0;
    logic [2:0]       mis_p0;
    logic             multi_hit_p0;

    logic [WIDTH-1:0] v_p1;
    logic [2:0]       mis_p1;
    logic             multi_p1;

    // ---- stage 0: combinational vote and mismatch reduction ----
    assign maj_p0       = (A & B) | (B & C) | (A & C);
    assign mis_p0       = {|(C ^ maj_p0), |(B ^ maj_p0), |(A ^ maj_p0)};
    assign multi_hit_p0 = (mis_p0[0] & mis_p0[1]) | (mis_p0[1] & mis_p0[2]) |
                          (mis_p0[0] & mis_p0[2]);

    // ---- stage 1: registered vote, flags and sticky multi-error ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            v_p1   <= '0;
            mis_p1 <= '0;
        end else if (CE) begin
            v_p1   <= maj_p0;
            mis_p1 <= mis_p0;
        end
    end

    // CLR_ERR clears the sticky flag even when CE is low.
    always_ff @(posedge CLK) begin
        if (RST || CLR_ERR)
            multi_p1 <= 1'b0;
        else if (CE && multi_hit_p0)
            multi_p1 <= 1'b1;
    end

    tmr_replica_mon #(.CNT_W(CNT_W), .FAULT_RUN(FAULT_RUN)) u_mon_a (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR_ERR(CLR_ERR),
        .mis(mis_p0[0]), .err_cnt(ERR_A), .fault(FAULT[0])
    );

    tmr_replica_mon #(.CNT_W(CNT_W), .FAULT_RUN(FAULT_RUN)) u_mon_b (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR_ERR(CLR_ERR),
        .mis(mis_p0[1]), .err_cnt(ERR_B), .fault(FAULT[1])
    );

    tmr_replica_mon #(.CNT_W(CNT_W), .FAULT_RUN(FAULT_RUN)) u_mon_c (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR_ERR(CLR_ERR),
        .mis(mis_p0[2]), .err_cnt(ERR_C), .fault(FAULT[2])
    );

    assign V     = v_p1;
    assign MIS   = mis_p1;
    assign MULTI = multi_p1;

endmodule

// File: tb/tb_tmr_vote_mon.sv
// Self-checking bench for tmr_vote_mon: table of input/expected records plus a
// saturation sequence, checked through a one-deep expected-result queue.
module tb_tmr_vote_mon;

    localparam int WIDTH     = 16;
    localparam int CNT_W     = 4;
    localparam int FAULT_RUN = 4;

    logic             clk;
    logic             rst, ce, clr;
    logic [WIDTH-1:0] a, b, c;
    logic [WIDTH-1:0] v;
    logic [2:0]       mis, fault;
    logic             multi;
    logic [CNT_W-1:0] err_a, err_b, err_c;

    tmr_vote_mon #(.WIDTH(WIDTH), .CNT_W(CNT_W), .FAULT_RUN(FAULT_RUN)) dut (
        .CLK(clk), .RST(rst), .CE(ce), .A(a), .B(b), .C(c), .CLR_ERR(clr),
        .V(v), .MIS(mis), .MULTI(multi),
        .ERR_A(err_a), .ERR_B(err_b), .ERR_C(err_c), .FAULT(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst, ce, clr;
        logic [WIDTH-1:0] a, b, c;
        logic [WIDTH-1:0] v;
        logic [2:0]       mis;
        logic             multi;
        logic [CNT_W-1:0] ea, eb, ec;
        logic [2:0]       fault;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic r, input logic e, input logic cl,
                                input logic [15:0] ia, input logic [15:0] ib,
                                input logic [15:0] ic, input logic [15:0] ev,
                                input logic [2:0] em, input logic emu,
                                input int ea, input int eb, input int ec,
                                input logic [2:0] ef);
        vec_t t;
        t.rst = r;  t.ce = e;  t.clr = cl;
        t.a = ia;   t.b = ib;  t.c = ic;
        t.v = ev;   t.mis = em; t.multi = emu;
        t.ea = CNT_W'(ea); t.eb = CNT_W'(eb); t.ec = CNT_W'(ec);
        t.fault = ef;
        return t;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, req);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        @(negedge clk);
        rst = t.rst; ce = t.ce; clr = t.clr;
        a = t.a; b = t.b; c = t.c;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL queue step %0d: got empty, expected one entry", idx);
        end else begin
            e = exp_q.pop_front();
            chk("V",     idx, v,                 e.v);
            chk("MIS",   idx, WIDTH'(mis),       WIDTH'(e.mis));
            chk("MULTI", idx, WIDTH'(multi),     WIDTH'(e.multi));
            chk("ERR_A", idx, WIDTH'(err_a),     WIDTH'(e.ea));
            chk("ERR_B", idx, WIDTH'(err_b),     WIDTH'(e.eb));
            chk("ERR_C", idx, WIDTH'(err_c),     WIDTH'(e.ec));
            chk("FAULT", idx, WIDTH'(fault),     WIDTH'(e.fault));
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; clr = 1'b0;
        a = '0; b = '0; c = '0;

        //             rst ce clr  A        B        C         V        MIS   MU  EA EB EC FAULT
        // reset with non-zero inputs
        tbl.push_back(mk(1, 1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b000, 0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(1, 1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b000, 0, 0, 0, 0, 3'b000));
        // agreement
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 1, 0, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 3'b000, 0, 0, 0, 0, 3'b000));
        // single-replica upset on C
        for (int i = 1; i <= 3; i++)
            tbl.push_back(mk(0, 1, 0, 16'h1234, 16'h1234, 16'h1235, 16'h1234, 3'b100, 0, 0, 0, i, 3'b000));
        tbl.push_back(mk(0, 1, 0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 3'b000, 0, 0, 0, 3, 3'b000));
        // B wrong four cycles in a row -> FAULTY on the fourth
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0, 1, 0, 16'h00FF, 16'h00FE, 16'h00FF, 16'h00FF, 3'b010, 0, 0, i, 3,
                             (i == 4) ? 3'b010 : 3'b000));
        tbl.push_back(mk(0, 1, 0, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 3'b000, 0, 0, 4, 3, 3'b010));
        tbl.push_back(mk(0, 1, 1, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 3'b000, 0, 0, 0, 0, 3'b000));
        // CLR_ERR wins over a same-cycle mismatch, MIS still updates
        tbl.push_back(mk(0, 1, 1, 16'h00F0, 16'h00FF, 16'h00FF, 16'h00FF, 3'b001, 0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(0, 1, 0, 16'h00F0, 16'h00FF, 16'h00FF, 16'h00FF, 3'b001, 0, 1, 0, 0, 3'b000));
        tbl.push_back(mk(0, 1, 0, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 3'b000, 0, 1, 0, 0, 3'b000));
        // run of 2, five CE-low cycles with wild inputs, then 2 more -> FAULTY
        tbl.push_back(mk(0, 1, 0, 16'h00F0, 16'h00FF, 16'h00FF, 16'h00FF, 3'b001, 0, 2, 0, 0, 3'b000));
        tbl.push_back(mk(0, 1, 0, 16'h00F0, 16'h00FF, 16'h00FF, 16'h00FF, 3'b001, 0, 3, 0, 0, 3'b000));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 16'h1111, 16'h2222, 16'h4444, 16'h00FF, 3'b001, 0, 3, 0, 0, 3'b000));
        tbl.push_back(mk(0, 1, 0, 16'h00F0, 16'h00FF, 16'h00FF, 16'h00FF, 3'b001, 0, 4, 0, 0, 3'b000));
        tbl.push_back(mk(0, 1, 0, 16'h00F0, 16'h00FF, 16'h00FF, 16'h00FF, 3'b001, 0, 5, 0, 0, 3'b001));
        tbl.push_back(mk(0, 1, 1, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 3'b000, 0, 0, 0, 0, 3'b000));
        // RST mid-run discards the run
        for (int i = 1; i <= 3; i++)
            tbl.push_back(mk(0, 1, 0, 16'h00F0, 16'h00FF, 16'h00FF, 16'h00FF, 3'b001, 0, i, 0, 0, 3'b000));
        tbl.push_back(mk(1, 1, 0, 16'h00F0, 16'h00FF, 16'h00FF, 16'h0000, 3'b000, 0, 0, 0, 0, 3'b000));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0, 1, 0, 16'h00F0, 16'h00FF, 16'h00FF, 16'h00FF, 3'b001, 0, i, 0, 0,
                             (i == 4) ? 3'b001 : 3'b000));
        tbl.push_back(mk(0, 1, 1, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 3'b000, 0, 0, 0, 0, 3'b000));
        // multi-replica disagreement, sticky MULTI
        tbl.push_back(mk(0, 1, 0, 16'h0001, 16'h0002, 16'h0003, 16'h0003, 3'b011, 1, 1, 1, 0, 3'b000));
        tbl.push_back(mk(0, 1, 0, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 3'b000, 1, 1, 1, 0, 3'b000));
        tbl.push_back(mk(0, 1, 1, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 3'b000, 0, 0, 0, 0, 3'b000));
        // CLR_ERR acts while CE is low; V and MIS hold
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0003, 16'h0003, 16'h0003, 3'b001, 0, 1, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 16'h5555, 16'h5555, 16'h5555, 16'h0003, 3'b001, 0, 0, 0, 0, 3'b000));

        foreach (tbl[i])
            apply(tbl[i], i);

        // saturation: A wrong for 20 cycles, counter pins at 15, fault from the 4th
        for (int i = 1; i <= 20; i++)
            apply(mk(0, 1, 0, 16'hF0F0, 16'h0F0F, 16'h0F0F, 16'h0F0F, 3'b001, 0,
                     (i > 15) ? 15 : i, 0, 0, (i >= 4) ? 3'b001 : 3'b000), 1000 + i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
